boot_rom_fetch: RTL and testbench



---
 rtl/boot_rom_fetch.sv | 131 +++++++++++++
 tb/tb_boot_rom_fetch.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/boot_rom_fetch.sv
// boot_rom_fetch
//   Instruction-side stage in front of the Hack CPU. It holds the program ROM,
//   boots it from a 16-bit valid/ready word stream, keeps the CPU in reset
//   while loading and for a short settle window afterwards, and then serves
//   the instruction addressed by the CPU pc with zero latency.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous, active-high; clears all state except ROM contents
//   load_start    one-cycle request to (re)load the program
//   load_data     program word, sampled only on an accept
//   load_valid    load_data valid this cycle
//   load_last     marks load_data as the final word, sampled only on an accept
//   load_ready    block accepts a word this cycle
//   pc            CPU program counter
//   instruction   word fed to the CPU instruction input (0 when not readable)
//   cpu_reset     registered CPU reset, high whenever the next state is not RUN
//   running       high in RUN
//   loaded_count  words written in the current load
//   overflow_err  sticky: ROM filled before load_last was seen
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | after reset; CPU held in reset, waiting for load_start
// S_LOAD | accepting program words into the ROM
// S_HOLD | load finished; CPU held in reset for HOLD_CYCLES cycles
// S_RUN  | CPU released; ROM readable up to loaded_count

module boot_rom_fetch #(
    parameter int ADDR_WIDTH  = 15,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic [15:0]           load_data,
    input  logic                  load_valid,
    input  logic                  load_last,
    output logic                  load_ready,
    input  logic [15:0]           pc,
    output logic [15:0]           instruction,
    output logic                  cpu_reset,
    output logic                  running,
    output logic [ADDR_WIDTH:0]   loaded_count,
    output logic                  overflow_err
);

    localparam int                  DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [3:0]          HOLD_INIT = 4'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_HOLD = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  hold_cnt;
    logic        wr_en;
    logic        rd_hit;
    logic [15:0] rom [DEPTH];

    assign wr_en = (state == S_LOAD) && load_valid;

    always_comb begin
        state_nxt  = state;
        load_ready = 1'b0;
        running    = 1'b0;
        case (state)
            S_IDLE: begin
                if (load_start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                load_ready = 1'b1;
                // The word that fills the last ROM slot ends the load even
                // without load_last; the overflow flag records that case.
                if (load_valid && (load_last || loaded_count == LAST_ADDR))
                    state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (hold_cnt <= 4'd1) state_nxt = S_RUN;
            end
            S_RUN: begin
                running = 1'b1;
                if (load_start) state_nxt = S_LOAD;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            cpu_reset    <= 1'b1;
            loaded_count <= '0;
            overflow_err <= 1'b0;
            hold_cnt     <= 4'd0;
        end else begin
            state     <= state_nxt;
            cpu_reset <= (state_nxt != S_RUN);

            if (state != S_LOAD && state_nxt == S_LOAD) begin
                loaded_count <= '0;
                overflow_err <= 1'b0;
            end else if (wr_en) begin
                loaded_count <= loaded_count + 1'b1;
                if (!load_last && loaded_count == LAST_ADDR)
                    overflow_err <= 1'b1;
            end

            if (state != S_HOLD && state_nxt == S_HOLD)
                hold_cnt <= HOLD_INIT;
            else if (state == S_HOLD && hold_cnt != 4'd0)
                hold_cnt <= hold_cnt - 4'd1;
        end
    end

    // ROM contents survive reset; readability is gated by loaded_count.
    always_ff @(posedge clk) begin
        if (wr_en) rom[loaded_count[ADDR_WIDTH-1:0]] <= load_data;
    end

    // loaded_count never exceeds DEPTH, so pc < loaded_count also implies
    // that the pc bits above the ROM address are zero.
    assign rd_hit      = running && ({1'b0, pc} < 17'(loaded_count));
    assign instruction = rd_hit ? rom[pc[ADDR_WIDTH-1:0]] : 16'h0000;

endmodule

// File: tb/tb_boot_rom_fetch.sv
module tb_boot_rom_fetch;

    localparam int AW    = 3;
    localparam int HC    = 2;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic [15:0] load_data;
    logic        load_valid;
    logic        load_last;
    logic        load_ready;
    logic [15:0] pc;
    logic [15:0] instruction;
    logic        cpu_reset;
    logic        running;
    logic [AW:0] loaded_count;
    logic        overflow_err;

    boot_rom_fetch #(.ADDR_WIDTH(AW), .HOLD_CYCLES(HC)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .load_last    (load_last),
        .load_ready   (load_ready),
        .pc           (pc),
        .instruction  (instruction),
        .cpu_reset    (cpu_reset),
        .running      (running),
        .loaded_count (loaded_count),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the words of the current program and how many are readable.
    logic [15:0] exp_mem [DEPTH];
    int          exp_cnt;
    bit          exp_ovf;
    logic [15:0] words   [DEPTH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_check(input logic [15:0] a);
        logic [15:0] e;
        pc = a;
        @(negedge clk);
        e = (a < exp_cnt) ? exp_mem[a[2:0]] : 16'h0000;
        chk("instr", instruction, e);
    endtask

    task automatic read_all();
        for (int a = 0; a <= DEPTH; a++) read_check(16'(a));
        read_check(16'h8000);
        read_check(16'h8000 | 16'($urandom_range(0, 7)));
        repeat (3) read_check(16'($urandom));
    endtask

    task automatic do_load(input int n, input bit with_last, input bit use_pat,
                           input logic [31:0] vpat);
        int idx;
        int cyc;
        bit v;
        load_start = 1'b1;
        pc         = 16'($urandom_range(0, 7));
        tick();
        load_start = 1'b0;
        exp_cnt    = 0;
        exp_ovf    = 1'b0;
        chk("start_ready",     load_ready,   1);
        chk("start_cpu_reset", cpu_reset,    1);
        chk("start_running",   running,      0);
        chk("start_count",     loaded_count, 0);
        chk("start_ovf",       overflow_err, 0);
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 200) begin
            v          = use_pat ? vpat[cyc % 32] : ($urandom_range(0, 2) != 0);
            load_valid = v;
            load_data  = v ? words[idx] : 16'($urandom);
            load_last  = v ? (with_last && idx == n - 1) : 1'($urandom);
            load_start = ($urandom_range(0, 3) == 0);
            pc         = 16'($urandom_range(0, 7));
            #1;
            chk("load_ready", load_ready,  1);
            chk("load_instr", instruction, 0);
            tick();
            cyc++;
            if (v) begin
                exp_mem[idx] = words[idx];
                idx++;
            end
            chk("load_count", loaded_count, idx);
        end
        chk("load_done", idx, n);
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data  = 16'hDEAD;
        load_last  = 1'b0;
        exp_cnt    = n;
        exp_ovf    = !with_last;
        for (int h = 0; h < HC; h++) begin
            chk("hold_ready",     load_ready,   0);
            chk("hold_cpu_reset", cpu_reset,    1);
            chk("hold_running",   running,      0);
            chk("hold_count",     loaded_count, n);
            chk("hold_ovf",       overflow_err, exp_ovf);
            chk("hold_instr",     instruction,  0);
            tick();
        end
        load_valid = 1'b0;
        chk("run_running",   running,      1);
        chk("run_cpu_reset", cpu_reset,    0);
        chk("run_count",     loaded_count, n);
        chk("run_ovf",       overflow_err, exp_ovf);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        load_start = 1'b0;
        load_data  = 16'h0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        pc         = 16'h0;
        exp_cnt    = 0;
        exp_ovf    = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();
        chk("rst_cpu_reset", cpu_reset,    1);
        chk("rst_ready",     load_ready,   0);
        chk("rst_running",   running,      0);
        chk("rst_count",     loaded_count, 0);
        chk("rst_ovf",       overflow_err, 0);
        chk("rst_instr",     instruction,  0);

        // Basic three-word program, valid every cycle.
        words[0] = 16'h0002; words[1] = 16'hEC10; words[2] = 16'h0003;
        do_load(3, 1'b1, 1'b1, 32'hFFFF_FFFF);
        read_all();

        // Same program with gaps in load_valid (1,0,0,1,0,1).
        do_load(3, 1'b1, 1'b1, 32'h0000_0029);
        read_all();

        // Fill the ROM without load_last.
        for (int i = 0; i < DEPTH; i++) words[i] = 16'h0010 + 16'(i);
        do_load(DEPTH, 1'b0, 1'b1, 32'hFFFF_FFFF);
        load_valid = 1'b1;
        load_data  = 16'hBEEF;
        tick();
        load_valid = 1'b0;
        chk("run_no_accept", loaded_count, DEPTH);
        read_all();

        // Reload from RUN with a single word.
        words[0] = 16'h7FFF;
        do_load(1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        read_all();

        // Asynchronous reset between edges in the middle of a load.
        for (int i = 0; i < 3; i++) words[i] = 16'($urandom);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            load_valid = 1'b1;
            load_data  = words[i];
            load_last  = 1'b0;
            tick();
        end
        load_valid = 1'b0;
        pc         = 16'h0;
        #3;
        reset = 1'b1;
        #1;
        exp_cnt = 0;
        chk("arst_cpu_reset", cpu_reset,    1);
        chk("arst_ready",     load_ready,   0);
        chk("arst_running",   running,      0);
        chk("arst_count",     loaded_count, 0);
        chk("arst_ovf",       overflow_err, 0);
        chk("arst_instr",     instruction,  0);
        #2;
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) words[i] = 16'($urandom);
        do_load(3, 1'b1, 1'b0, 32'h0);
        read_all();

        // Randomized programs.
        repeat (8) begin
            int  n;
            bit  wl;
            n  = $urandom_range(1, DEPTH);
            wl = (n < DEPTH) ? 1'b1 : 1'($urandom);
            for (int i = 0; i < DEPTH; i++) words[i] = 16'($urandom);
            do_load(n, wl, 1'b0, 32'h0);
            read_all();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
